// File: rtl/ysyx_24080014_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080014_pkg
// Purpose  : Shared funct3 codes, LSU state encoding and bus response codes.
// Revision : 1.0
// ============================================================================
package ysyx_24080014_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  // Size lives in funct3[1:0]; anything other than byte/half is a word access.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      F3_LB[1:0]: return 1'b0;
      F3_LH[1:0]: return off[0];
      default:    return off != 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080014_lsu_align
// Purpose  : Combinational load lane extraction/extension and store lane shift.
// Revision : 1.0
// ============================================================================
module ysyx_24080014_lsu_align
  import ysyx_24080014_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic [31:0] shifted;
  logic        is_unsigned;

  always_comb begin
    shifted     = rdata >> {off, 3'b000};
    is_unsigned = funct3[2];
    wdata       = store_data << {off, 3'b000};
    case (funct3[1:0])
      F3_LB[1:0]: begin
        load_data = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        wstrb     = 4'b0001 << off;
      end
      F3_LH[1:0]: begin
        load_data = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        wstrb     = 4'b0011 << off;
      end
      default: begin
        load_data = rdata;
        wstrb     = 4'b1111;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080014_lsu
// Purpose  : Load/store unit driving an AXI4-Lite-style data bus.
// Revision : 1.0
// ============================================================================
module ysyx_24080014_lsu
  import ysyx_24080014_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              mem_ready,
  output logic [31:0]       rd_data,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  lsu_state_e        state, state_d;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              aw_pend, w_pend;
  logic              misaligned;
  logic [ADDR_W-1:0] word_addr;
  logic [2:0]        al_funct3;
  logic [1:0]        al_off;
  logic [31:0]       al_load, al_wdata;
  logic [3:0]        al_wstrb;

  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
  assign word_addr  = {req_addr[ADDR_W-1:2], 2'b00};

  // The aligner serves the store path at acceptance and the load path in R.
  assign al_funct3 = (state == S_IDLE) ? req_funct3    : funct3_q;
  assign al_off    = (state == S_IDLE) ? req_addr[1:0] : off_q;

  ysyx_24080014_lsu_align u_align (
    .funct3     (al_funct3),
    .off        (al_off),
    .rdata      (rdata),
    .store_data (req_wdata),
    .load_data  (al_load),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      err      <= 1'b0;
      rd_data  <= 32'b0;
      araddr   <= '0;
      awaddr   <= '0;
      wdata    <= 32'b0;
      wstrb    <= 4'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            err      <= misaligned;
            if (misaligned) begin
              if (!req_store) rd_data <= 32'b0;
            end else if (req_store) begin
              awaddr  <= word_addr;
              wdata   <= al_wdata;
              wstrb   <= al_wstrb;
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
            end else begin
              araddr <= word_addr;
            end
          end
        end
        S_R: begin
          if (rvalid) begin
            err     <= (rresp != RESP_OKAY);
            rd_data <= (rresp != RESP_OKAY) ? 32'b0 : al_load;
          end
        end
        S_AW_W: begin
          if (awready) aw_pend <= 1'b0;
          if (wready)  w_pend  <= 1'b0;
        end
        S_B: begin
          if (bvalid) err <= (bresp != RESP_OKAY);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    busy      = (state != S_IDLE);
    mem_ready = (state == S_DONE);
    arvalid   = (state == S_AR);
    rready    = (state == S_R);
    bready    = (state == S_B);
    awvalid   = aw_pend;
    wvalid    = w_pend;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (misaligned)     state_d = S_DONE;
          else if (req_store) state_d = S_AW_W;
          else                state_d = S_AR;
        end
      end
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid)  state_d = S_DONE;
      S_AW_W: if ((!aw_pend || awready) && (!w_pend || wready)) state_d = S_B;
      S_B:    if (bvalid)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24080014_lsu
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, mem_ready, err;
  logic [31:0] rd_data;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;

  int          t_done, t_pulses, t_arv, t_awv, t_stab, t_drop, t_busy, t_aw_cyc, t_w_cyc;
  logic        t_err;
  logic [31:0] t_rd, t_araddr, t_awaddr, t_wdata;
  logic [3:0]  t_wstrb;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  ysyx_24080014_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .mem_ready(mem_ready), .rd_data(rd_data), .err(err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---- reference model --------------------------------------------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int     n   = nbytes(f3);
    int     off = a % 4;
    longint v   = w;
    v = (v >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
    if (n < 4 && f3 < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int s = ((1 << nbytes(f3)) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic bit lanes_ok(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] got);
    int off = a % 4;
    for (int k = 0; k < nbytes(f3); k++)
      if (((got >> (8 * (off + k))) & 32'hFF) != ((wd >> (8 * k)) & 32'hFF)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_lat(input bit st, input bit mis, input int ar_d, r_d, aw_d, w_d, b_d);
    if (mis) return 2;
    if (!st) return 4 + ar_d + r_d;
    return 4 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
  endfunction

  // ---- request driver + bus slave; records observations in t_* ----------
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int ar_d, r_d, aw_d, w_d, b_d,
                         input logic [31:0] word, input logic [1:0] rr, br);
    logic p_arv, p_rr, p_awv, p_wv, p_br;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0] p_wstrb;
    int ar_w, aw_w, w_w, r_left, b_left;
    bit r_pend, b_pend, ar_tk, aw_tk, w_tk, b_tk;
    {p_arv, p_rr, p_awv, p_wv, p_br} = '0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
    ar_w = 0; aw_w = 0; w_w = 0; r_left = 0; b_left = 0;
    {r_pend, b_pend, ar_tk, aw_tk, w_tk, b_tk} = '0;
    t_done = 0; t_pulses = 0; t_arv = 0; t_awv = 0; t_stab = 0; t_drop = 0; t_busy = 0;
    t_aw_cyc = 0; t_w_cyc = 0; t_err = 1'bx; t_rd = 'x;
    t_araddr = 'x; t_awaddr = 'x; t_wdata = 'x; t_wstrb = 'x;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 2; c <= 60; c++) begin
      if (p_arv && arready) begin ar_tk = 1; t_araddr = p_araddr; r_pend = 1; r_left = r_d; end
      if (p_rr && rvalid) r_pend = 0;
      if (p_awv && awready) begin aw_tk = 1; t_awaddr = p_awaddr; t_aw_cyc = c - 1; end
      if (p_wv && wready) begin w_tk = 1; t_wdata = p_wdata; t_wstrb = p_wstrb; t_w_cyc = c - 1; end
      if (p_br && bvalid) b_pend = 0;
      if (aw_tk && w_tk && !b_tk) begin b_tk = 1; b_pend = 1; b_left = b_d; end
      if (p_arv && !arready && (!arvalid || araddr != p_araddr)) t_stab++;
      if (p_awv && !awready && (!awvalid || awaddr != p_awaddr)) t_stab++;
      if (p_wv && !wready && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) t_stab++;
      if ((ar_tk && arvalid) || (aw_tk && awvalid) || (w_tk && wvalid)) t_drop++;
      if (arvalid) t_arv++;
      if (awvalid || wvalid) t_awv++;
      if (mem_ready) begin
        t_pulses++;
        if (t_done == 0) begin t_done = c; t_err = err; t_rd = rd_data; end
      end
      if (t_done == 0 && !busy) t_busy++;
      if (t_done != 0 && c == t_done + 1 && busy) t_busy++;
      arready = 1'b0;
      if (arvalid) begin if (ar_w >= ar_d) arready = 1'b1; else ar_w++; end
      awready = 1'b0;
      if (awvalid) begin if (aw_w >= aw_d) awready = 1'b1; else aw_w++; end
      wready = 1'b0;
      if (wvalid) begin if (w_w >= w_d) wready = 1'b1; else w_w++; end
      rvalid = 1'b0; rresp = 2'b00; rdata = $urandom;
      if (r_pend) begin
        if (r_left == 0) begin rvalid = 1'b1; rdata = word; rresp = rr; end else r_left--;
      end
      bvalid = 1'b0; bresp = 2'b00;
      if (b_pend) begin
        if (b_left == 0) begin bvalid = 1'b1; bresp = br; end else b_left--;
      end
      p_arv = arvalid; p_rr = rready; p_awv = awvalid; p_wv = wvalid; p_br = bready;
      p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
      if (t_done != 0 && c >= t_done + 2) break;
      @(posedge clk); #1;
    end
    {arready, rvalid, awready, wready, bvalid} = '0;
    rresp = 2'b00; bresp = 2'b00;
  endtask

  // ---- scenarios --------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    {req_valid, req_store, arready, rvalid, awready, wready, bvalid} = '0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; rdata = '0; rresp = '0; bresp = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, mem_ready, err, arvalid, awvalid, wvalid, rready, bready} !== 8'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000000",
        {busy, mem_ready, err, arvalid, awvalid, wvalid, rready, bready});
    end
    checks++;
    if ({rd_data, araddr, awaddr, wdata, wstrb} !== 132'b0) begin
      failures++; $display("FAIL reset_data rd=%h ar=%h aw=%h wd=%h ws=%b exp=all zero",
        rd_data, araddr, awaddr, wdata, wstrb);
    end
    rst_n = 1'b1;
    model_rd = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_basic();
    run_txn(0, 3'b010, 32'h8000_0004, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00);
    checks++;
    if (t_araddr !== 32'h8000_0004) begin failures++; $display("FAIL lw_araddr got=%h exp=80000004", t_araddr); end
    checks++;
    if (t_done !== 4) begin failures++; $display("FAIL lw_latency got=%0d exp=4", t_done); end
    checks++;
    if (t_rd !== 32'hDEADBEEF || t_err !== 1'b0) begin
      failures++; $display("FAIL lw_result rd=%h err=%b exp rd=deadbeef err=0", t_rd, t_err);
    end
    checks++;
    if (t_pulses !== 1 || t_busy !== 0) begin
      failures++; $display("FAIL lw_pulse pulses=%0d busy_errs=%0d exp 1/0", t_pulses, t_busy);
    end
    model_rd = 32'hDEADBEEF;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s[4]   = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [31:0] addrs[4] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002};
    logic [31:0] exps[4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8012, 32'hFFFF_8012};
    for (int i = 0; i < 4; i++) begin
      run_txn(0, f3s[i], addrs[i], 32'h0, 0, 0, 0, 0, 0, 32'h8012_3456, 2'b00, 2'b00);
      checks++;
      if (t_rd !== exps[i] || t_err !== 1'b0 || t_done !== 4) begin
        failures++; $display("FAIL load_ext[%0d] rd=%h err=%b lat=%0d exp rd=%h err=0 lat=4",
          i, t_rd, t_err, t_done, exps[i]);
      end
      model_rd = exps[i];
    end
  endtask

  task automatic test_store_sh();
    run_txn(1, 3'b001, 32'h8000_0006, 32'h0000_ABCD, 0, 0, 2, 0, 0, 32'h0, 2'b00, 2'b00);
    checks++;
    if (t_wstrb !== 4'b1100 || t_wdata[31:16] !== 16'hABCD) begin
      failures++; $display("FAIL sh_lanes wstrb=%b wdata=%h exp wstrb=1100 wdata[31:16]=abcd", t_wstrb, t_wdata);
    end
    checks++;
    if (t_w_cyc !== 2 || t_aw_cyc !== 4 || t_drop !== 0 || t_stab !== 0) begin
      failures++; $display("FAIL sh_handshake w=%0d aw=%0d drop=%0d stab=%0d exp 2/4/0/0",
        t_w_cyc, t_aw_cyc, t_drop, t_stab);
    end
    checks++;
    if (t_done !== 6 || t_pulses !== 1 || t_err !== 1'b0) begin
      failures++; $display("FAIL sh_done lat=%0d pulses=%0d err=%b exp 6/1/0", t_done, t_pulses, t_err);
    end
    checks++;
    if (t_rd !== model_rd) begin failures++; $display("FAIL sh_rd_held got=%h exp=%h", t_rd, model_rd); end
  endtask

  task automatic test_misaligned();
    run_txn(0, 3'b010, 32'h8000_0002, 32'h0, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 2'b00);
    checks++;
    if (t_done !== 2 || t_err !== 1'b1 || t_rd !== 32'h0 || t_arv !== 0) begin
      failures++; $display("FAIL lw_misaligned lat=%0d err=%b rd=%h arv=%0d exp 2/1/0/0", t_done, t_err, t_rd, t_arv);
    end
    model_rd = 32'h0;
    run_txn(1, 3'b001, 32'h8000_0001, 32'h1111_2222, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    checks++;
    if (t_done !== 2 || t_err !== 1'b1 || t_awv !== 0 || t_busy !== 0) begin
      failures++; $display("FAIL sh_misaligned lat=%0d err=%b awv=%0d busy_errs=%0d exp 2/1/0/0",
        t_done, t_err, t_awv, t_busy);
    end
  endtask

  task automatic test_store_err();
    run_txn(1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b10);
    checks++;
    if (t_done !== 4 || t_err !== 1'b1 || t_wstrb !== 4'b1111 || t_wdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL sw_bresp lat=%0d err=%b wstrb=%b wdata=%h exp 4/1/1111/cafef00d",
        t_done, t_err, t_wstrb, t_wdata);
    end
  endtask

  task automatic test_ar_delay();
    run_txn(0, 3'b010, 32'h8000_0020, 32'h0, 3, 0, 0, 0, 0, 32'h0BAD_F00D, 2'b00, 2'b00);
    checks++;
    if (t_stab !== 0 || t_arv !== 4 || t_araddr !== 32'h8000_0020) begin
      failures++; $display("FAIL ar_delay_stable stab=%0d arv=%0d araddr=%h exp 0/4/80000020", t_stab, t_arv, t_araddr);
    end
    checks++;
    if (t_done !== 7 || t_rd !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL ar_delay_result lat=%0d rd=%h exp 7/0badf00d", t_done, t_rd);
    end
    model_rd = 32'h0BAD_F00D;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    @(posedge clk); #1;
    req_valid = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    checks++;
    if (rready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_r rready=%b exp=1", rready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mem_ready, arvalid, rready, awvalid, wvalid, bready} !== 7'b0 || rd_data !== 32'h0 || araddr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_outputs ctrl=%b rd=%h araddr=%h exp all zero",
        {busy, mem_ready, arvalid, rready, awvalid, wvalid, bready}, rd_data, araddr);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", pulses); end
    run_txn(0, 3'b010, 32'h8000_0008, 32'h0, 0, 0, 0, 0, 0, 32'h5A5A_1234, 2'b00, 2'b00);
    checks++;
    if (t_done !== 4 || t_rd !== 32'h5A5A_1234 || t_err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_recover lat=%0d rd=%h err=%b exp 4/5a5a1234/0", t_done, t_rd, t_err);
    end
    model_rd = 32'h5A5A_1234;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      bit          st   = $urandom_range(0, 1);
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = 32'h8000_0000 | $urandom_range(0, 255);
      logic [31:0] wd   = $urandom;
      logic [31:0] word = $urandom;
      int ar_d = $urandom_range(0, 3), r_d = $urandom_range(0, 3);
      int aw_d = $urandom_range(0, 3), w_d = $urandom_range(0, 3), b_d = $urandom_range(0, 3);
      logic [1:0]  rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      logic [1:0]  br = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bit          mis = ref_mis(f3, a);
      bit          e_err = mis || (st ? (br != 0) : (rr != 0));
      logic [31:0] e_rd;
      int          e_lat = ref_lat(st, mis, ar_d, r_d, aw_d, w_d, b_d);
      if (st) e_rd = model_rd;
      else    e_rd = e_err ? 32'h0 : ref_load(f3, a, word);
      run_txn(st, f3, a, wd, ar_d, r_d, aw_d, w_d, b_d, word, rr, br);
      checks++;
      if (t_done !== e_lat || t_pulses !== 1 || t_busy !== 0) begin
        failures++; $display("FAIL rand[%0d] timing lat=%0d pulses=%0d busy_errs=%0d exp %0d/1/0",
          it, t_done, t_pulses, t_busy, e_lat);
      end
      checks++;
      if (t_err !== e_err || t_rd !== e_rd) begin
        failures++; $display("FAIL rand[%0d] result st=%0d f3=%b a=%h err=%b rd=%h exp err=%b rd=%h",
          it, st, f3, a, t_err, t_rd, e_err, e_rd);
      end
      checks++;
      if (t_stab !== 0 || t_drop !== 0) begin
        failures++; $display("FAIL rand[%0d] valid_rules stab=%0d drop=%0d exp 0/0", it, t_stab, t_drop);
      end
      if (mis) begin
        checks++;
        if (t_arv !== 0 || t_awv !== 0) begin
          failures++; $display("FAIL rand[%0d] mis_bus arv=%0d awv=%0d exp 0/0", it, t_arv, t_awv);
        end
      end else if (st) begin
        checks++;
        if (t_wstrb !== ref_strb(f3, a) || !lanes_ok(f3, a, wd, t_wdata) || t_awaddr[31:2] !== a[31:2]) begin
          failures++; $display("FAIL rand[%0d] store f3=%b a=%h wd=%h wstrb=%b wdata=%h awaddr=%h exp wstrb=%b",
            it, f3, a, wd, t_wstrb, t_wdata, t_awaddr, ref_strb(f3, a));
        end
      end else begin
        checks++;
        if (t_araddr !== (a & 32'hFFFF_FFFC)) begin
          failures++; $display("FAIL rand[%0d] araddr got=%h exp=%h", it, t_araddr, a & 32'hFFFF_FFFC);
        end
      end
      if (!st) model_rd = e_rd;
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_ext();
    test_store_sh();
    test_misaligned();
    test_store_err();
    test_ar_delay();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
